// File: rtl/mips_irq_pkg.sv
// mips_irq_pkg: shared types and constants for the mips interrupt controller.
package mips_irq_pkg;
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_t;
    localparam int IRQ_ID_W = 4;
    localparam int IRQ_ADDR_W = 32;
    localparam logic [IRQ_ADDR_W-1:0] VEC_BASE_DEF = 32'h0000_0000;
    localparam logic [IRQ_ADDR_W-1:0] VEC_STRIDE_DEF = 32'h0000_0020;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest set index wins.
module irq_prio_enc
    import mips_irq_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0]    req_i,
    output logic                any_o,
    output logic [IRQ_ID_W-1:0] id_o
);
    always_comb begin
        any_o = |req_i;
        id_o  = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (req_i[i]) id_o = IRQ_ID_W'(i);
    end
endmodule

// File: rtl/mips_irq_ctrl.sv
// mips_irq_ctrl: edge-captured, maskable, fixed-priority interrupt controller that
// drives the mips irq/irq_addr/irq_ack handshake and waits for RES before re-arming.
module mips_irq_ctrl
    import mips_irq_pkg::*;
#(
    parameter int                    N_SRC      = 4,
    parameter logic [IRQ_ADDR_W-1:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [IRQ_ADDR_W-1:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_SRC-1:0]      irq_src_i,
    input  logic [N_SRC-1:0]      irq_mask_i,
    input  logic                  irq_ack_i,
    input  logic                  isr_done_i,
    output logic                  irq_o,
    output logic [IRQ_ADDR_W-1:0] irq_addr_o,
    output logic [IRQ_ID_W-1:0]   irq_active_id_o,
    output logic                  irq_busy_o,
    output logic [N_SRC-1:0]      pending_o
);
    irq_state_t            state_q, state_d;
    logic [N_SRC-1:0]      src_q, pending_q, pending_d, clr;
    logic [IRQ_ID_W-1:0]   id_q, id_d, enc_id;
    logic [IRQ_ADDR_W-1:0] addr_q, addr_d;
    logic                  enc_any, take_ack, launch;

    irq_prio_enc #(.N_SRC(N_SRC)) u_enc (
        .req_i (pending_q & ~irq_mask_i),
        .any_o (enc_any),
        .id_o  (enc_id)
    );

    assign launch    = (state_q == IDLE) && enc_any;
    assign take_ack  = (state_q == REQ) && irq_ack_i;
    assign clr       = take_ack ? (N_SRC'(1) << id_q) : '0;
    // A new rise on the clearing cycle is a fresh event, so it must survive the clear.
    assign pending_d = (pending_q & ~clr) | (irq_src_i & ~src_q);
    assign id_d      = launch ? enc_id : id_q;
    assign addr_d    = launch ? VEC_BASE + IRQ_ADDR_W'(enc_id) * VEC_STRIDE : addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            src_q     <= '0;
            pending_q <= '0;
            id_q      <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= irq_src_i;
            pending_q <= pending_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enc_any) state_d = REQ;
            REQ:     if (irq_ack_i) state_d = SERVICE;
            SERVICE: if (isr_done_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_o           = (state_q == REQ);
        irq_busy_o      = (state_q != IDLE);
        irq_addr_o      = addr_q;
        irq_active_id_o = id_q;
        pending_o       = pending_q;
    end
endmodule

// File: tb/tb_mips_irq_ctrl.sv
// tb_mips_irq_ctrl: directed scenario tests for mips_irq_ctrl with hand-computed expectations.
module tb_mips_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  irq_src, irq_mask;
    logic        irq_ack, isr_done;
    logic        irq, irq_busy;
    logic [31:0] irq_addr;
    logic [3:0]  irq_id, pending;
    int          pass_cnt = 0, total_cnt = 0;

    mips_irq_ctrl dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .irq_src_i       (irq_src),
        .irq_mask_i      (irq_mask),
        .irq_ack_i       (irq_ack),
        .isr_done_i      (isr_done),
        .irq_o           (irq),
        .irq_addr_o      (irq_addr),
        .irq_active_id_o (irq_id),
        .irq_busy_o      (irq_busy),
        .pending_o       (pending)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq_src = '0; irq_mask = '0; irq_ack = 1'b0; isr_done = 1'b0;
        #12;
        total_cnt++; if ({irq, irq_busy, pending, irq_addr, irq_id} !== 41'd0) $display("FAIL reset_init got irq=%b busy=%b pend=%b addr=%h id=%0d want all zero", irq, irq_busy, pending, irq_addr, irq_id); else pass_cnt++;
        tick(); rst_n = 1'b1;
        irq_src = 4'b0100; tick(); irq_src = '0; tick();
        total_cnt++; if ({irq, irq_addr} !== {1'b1, 32'h40}) $display("FAIL reset_preq got irq=%b addr=%h want 1/00000040", irq, irq_addr); else pass_cnt++;
        irq_src = 4'b0001; tick();
        irq_src = '0; rst_n = 1'b0; #1;
        total_cnt++; if ({irq, irq_busy, pending} !== 6'd0) $display("FAIL reset_midreq got irq=%b busy=%b pend=%b want 0/0/0000", irq, irq_busy, pending); else pass_cnt++;
        tick(); rst_n = 1'b1; tick(3);
        total_cnt++; if ({irq, irq_busy, pending} !== 6'd0) $display("FAIL reset_release got irq=%b busy=%b pend=%b want 0/0/0000", irq, irq_busy, pending); else pass_cnt++;
    endtask

    task automatic test_single();
        irq_src = 4'b0010; tick(); irq_src = '0;
        total_cnt++; if ({irq, pending} !== 5'b0_0010) $display("FAIL single_pend got irq=%b pend=%b want 0/0010", irq, pending); else pass_cnt++;
        tick();
        total_cnt++; if ({irq, irq_busy, irq_addr, irq_id} !== {1'b1, 1'b1, 32'h20, 4'd1}) $display("FAIL single_req got irq=%b busy=%b addr=%h id=%0d want 1/1/00000020/1", irq, irq_busy, irq_addr, irq_id); else pass_cnt++;
        tick();
        total_cnt++; if ({irq, irq_addr} !== {1'b1, 32'h20}) $display("FAIL single_hold got irq=%b addr=%h want 1/00000020", irq, irq_addr); else pass_cnt++;
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        total_cnt++; if ({irq, irq_busy, pending, irq_addr} !== {1'b0, 1'b1, 4'b0000, 32'h20}) $display("FAIL single_ack got irq=%b busy=%b pend=%b addr=%h want 0/1/0000/00000020", irq, irq_busy, pending, irq_addr); else pass_cnt++;
        isr_done = 1'b1; tick(); isr_done = 1'b0;
        total_cnt++; if ({irq, irq_busy} !== 2'b00) $display("FAIL single_done got irq=%b busy=%b want 0/0", irq, irq_busy); else pass_cnt++;
    endtask

    task automatic test_priority();
        irq_src = 4'b1100; tick(); irq_src = '0; tick();
        total_cnt++; if ({irq, irq_addr, irq_id} !== {1'b1, 32'h40, 4'd2}) $display("FAIL prio_first got irq=%b addr=%h id=%0d want 1/00000040/2", irq, irq_addr, irq_id); else pass_cnt++;
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        total_cnt++; if (pending !== 4'b1000) $display("FAIL prio_pend got %b want 1000", pending); else pass_cnt++;
        isr_done = 1'b1; tick(); isr_done = 1'b0; tick();
        total_cnt++; if ({irq, irq_addr, irq_id} !== {1'b1, 32'h60, 4'd3}) $display("FAIL prio_second got irq=%b addr=%h id=%0d want 1/00000060/3", irq, irq_addr, irq_id); else pass_cnt++;
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        isr_done = 1'b1; tick(); isr_done = 1'b0;
    endtask

    task automatic test_mask();
        irq_mask = 4'b0001; irq_src = 4'b0001; tick(); irq_src = '0; tick(3);
        total_cnt++; if ({irq, irq_busy, pending} !== 6'b00_0001) $display("FAIL mask_block got irq=%b busy=%b pend=%b want 0/0/0001", irq, irq_busy, pending); else pass_cnt++;
        irq_mask = '0; tick();
        total_cnt++; if ({irq, irq_addr} !== {1'b1, 32'h0}) $display("FAIL mask_open got irq=%b addr=%h want 1/00000000", irq, irq_addr); else pass_cnt++;
        irq_mask = 4'b0001; tick();
        total_cnt++; if ({irq, irq_addr, irq_id} !== {1'b1, 32'h0, 4'd0}) $display("FAIL mask_noretarget got irq=%b addr=%h id=%0d want 1/00000000/0", irq, irq_addr, irq_id); else pass_cnt++;
        irq_mask = '0; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        isr_done = 1'b1; tick(); isr_done = 1'b0;
    endtask

    task automatic test_stuck();
        irq_src = 4'b1000; tick(); irq_src = '0; tick();
        total_cnt++; if ({irq, irq_addr} !== {1'b1, 32'h60}) $display("FAIL stuck_req got irq=%b addr=%h want 1/00000060", irq, irq_addr); else pass_cnt++;
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_src = 4'b0010; tick(); irq_src = '0; tick(5);
        total_cnt++; if ({irq, irq_busy, pending} !== 6'b01_0010) $display("FAIL stuck_hold got irq=%b busy=%b pend=%b want 0/1/0010", irq, irq_busy, pending); else pass_cnt++;
        isr_done = 1'b1; tick(); isr_done = 1'b0;
        total_cnt++; if ({irq, irq_busy} !== 2'b00) $display("FAIL stuck_idle got irq=%b busy=%b want 0/0", irq, irq_busy); else pass_cnt++;
        tick();
        total_cnt++; if ({irq, irq_addr} !== {1'b1, 32'h20}) $display("FAIL stuck_next got irq=%b addr=%h want 1/00000020", irq, irq_addr); else pass_cnt++;
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        isr_done = 1'b1; tick(); isr_done = 1'b0;
    endtask

    task automatic test_boundary();
        irq_src = 4'b0100; tick(); irq_src = '0; tick();
        total_cnt++; if ({irq, irq_addr} !== {1'b1, 32'h40}) $display("FAIL bnd_req got irq=%b addr=%h want 1/00000040", irq, irq_addr); else pass_cnt++;
        irq_ack = 1'b1; irq_src = 4'b0100; tick(); irq_ack = 1'b0; irq_src = '0;
        total_cnt++; if ({irq, irq_busy, pending} !== 6'b01_0100) $display("FAIL bnd_rise_on_ack got irq=%b busy=%b pend=%b want 0/1/0100", irq, irq_busy, pending); else pass_cnt++;
        isr_done = 1'b1; tick(); isr_done = 1'b0; tick();
        total_cnt++; if ({irq, irq_addr} !== {1'b1, 32'h40}) $display("FAIL bnd_rereq got irq=%b addr=%h want 1/00000040", irq, irq_addr); else pass_cnt++;
        irq_ack = 1'b1; isr_done = 1'b1; tick(); irq_ack = 1'b0; isr_done = 1'b0;
        total_cnt++; if ({irq, irq_busy, pending} !== 6'b01_0000) $display("FAIL bnd_ack_done got irq=%b busy=%b pend=%b want 0/1/0000", irq, irq_busy, pending); else pass_cnt++;
        tick(2);
        total_cnt++; if ({irq, irq_busy} !== 2'b01) $display("FAIL bnd_service_hold got irq=%b busy=%b want 0/1", irq, irq_busy); else pass_cnt++;
        isr_done = 1'b1; tick(); isr_done = 1'b0;
        total_cnt++; if ({irq, irq_busy} !== 2'b00) $display("FAIL bnd_final got irq=%b busy=%b want 0/0", irq, irq_busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_stuck();
        test_boundary();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
